axil_isram: RTL and testbench
=============================

# axil_isram

AXI-lite read-only instruction memory slave. It sits directly upstream of the instruction fetch unit and answers that unit's AR/R requests with 32-bit instruction words. Response latency is either fixed or pseudo-random, so the fetch handshake can be exercised under realistic back-pressure. A synchronous backdoor write port preloads program images. Exactly one read is outstanding at a time.

## Interface
Parameters:
- ADDR_LEN, 32, address width.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 14, log2 of the word count (default 64 KiB).
- DELAY_MODE, 0, 0 = fixed delay, 1 = LFSR random delay.
- FIXED_DELAY, 1, 4-bit extra wait cycles used in fixed mode (0..15).
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- arvalid  in  1  read-address valid
- arready  out  1  read-address ready
- araddr  in  ADDR_LEN  byte address
- rvalid  out  1  read-data valid
- rready  in  1  read-data ready
- rresp  out  2  response code
- rdata  out  32  instruction word
- bd_wen  in  1  backdoor write enable
- bd_addr  in  DEPTH_LOG2  word index
- bd_wdata  in  32  write data
- bd_wstrb  in  4  byte enables

## Operation
- State machine has three states:
  - IDLE: arready = init_done.
  - WAIT: decrementing the delay counter.
  - RESP: rvalid = 1.
- init_done resets to 0 and is set on the first clk edge after reset release.
- IDLE to WAIT on arvalid & arready:
  - latch araddr;
  - load the counter with delay D: FIXED_DELAY in fixed mode, lfsr[2:0] (0..7) in random mode.
- WAIT to RESP when the counter is 0. On that edge, register rdata and rresp.
- If D = 0, the FSM goes IDLE to RESP with no WAIT cycle.
- RESP to IDLE on rvalid & rready.
- Address check on the latched address, offset = addr - BASE_ADDR:
  - offset[1:0] != 0 → rresp 2'b10 (SLVERR), rdata 0.
  - else offset >= 4 << DEPTH_LOG2 (including BASE_ADDR wrap-under) → rresp 2'b11 (DECERR), rdata 0.
  - else rresp 2'b00 (OKAY), rdata = mem[offset >> 2].
- Backdoor write: on a clk edge with bd_wen high, write bytes of mem[bd_addr] selected by bd_wstrb. This is independent of FSM state.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle, resets to LFSR_SEED.

## Timing
- Reset values: arready 0, rvalid 0, rresp 2'b00, rdata 0, state IDLE, init_done 0, LFSR LFSR_SEED. Memory contents are not reset.
- arready is 1 from the second cycle after reset release.
- Latency: an AR handshake at edge N gives rvalid high from edge N+1+D, i.e. D+1 cycles.
- rvalid, rdata and rresp stay stable while rvalid & ~rready.
- After an R handshake at edge M, arready is high from edge M.
- No AR acceptance in the same cycle as R completion. Peak throughput is one read per D+2 cycles.
- arready stays low in WAIT and RESP. arvalid there is ignored and is not queued.
- A backdoor write to the addressed word on the same edge as RESP entry is not visible: rdata takes the pre-write contents. Writes on earlier edges are visible.
- Reset asserted mid-WAIT or mid-RESP aborts the transaction immediately: rvalid drops to 0 and the pending response is discarded.

## Structure
- Shared package isram_pkg holds:
  - response constants RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11;
  - the FSM state enum (IDLE, WAIT, RESP);
  - the LFSR tap constant.
- One sub-module, lfsr8: an 8-bit Fibonacci LFSR with seed parameter and enable.
- Memory is an inferred array of 32-bit words.

## Test plan
- Reset: hold rst_n low 3 cycles → arready 0, rvalid 0, rdata 0, rresp 0; arready 1 on the second cycle after release.
- Fixed mode, FIXED_DELAY=2, preload mem[0]=32'h0000_0013, read 32'h8000_0000 with rready=1 → rvalid rises exactly 3 cycles after the AR handshake, rdata 32'h0000_0013, rresp 2'b00, arready back high after the R handshake.
- Back-pressure: rready held 0 for 5 cycles in RESP → rvalid, rdata and rresp unchanged each cycle; completes on the first rready=1 edge.
- Errors: araddr 32'h8000_0002 → rresp 2'b10, rdata 0; araddr 32'h8001_0000 (DEPTH_LOG2=14) → 2'b11; araddr 32'h7FFF_FFFC → 2'b11.
- Random mode: 1000 reads of random preloaded words with random rready → all data match, every latency falls in 1..8 cycles, and at least one latency of 1 and one of 8 is observed.
- Reset mid-WAIT (FIXED_DELAY=5, reset 2 cycles after handshake) → rvalid never asserts; after release, a new read returns correct data.

Source files
------------

// File: rtl/isram_pkg.sv
// rtl/isram_pkg.sv - shared constants and types for the instruction SRAM slave
// Holds AXI response codes, the read FSM state enum and the delay LFSR tap mask.
package isram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR used as the random response-delay source
// Ports: clk, rst_n (async active-low), en (advance), lfsr (current state).
module lfsr8
    import isram_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/axil_isram.sv
// rtl/axil_isram.sv - AXI-lite read-only instruction memory with fixed or random response delay
// Ports: clk, rst_n (async active-low); AR channel arvalid/arready/araddr;
//        R channel rvalid/rready/rresp/rdata; backdoor preload bd_wen/bd_addr/bd_wdata/bd_wstrb.
module axil_isram
    import isram_pkg::*;
#(
    parameter int                  ADDR_LEN    = 32,
    parameter logic [ADDR_LEN-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                  DEPTH_LOG2  = 14,
    parameter int                  DELAY_MODE  = 0,
    parameter int                  FIXED_DELAY = 1,
    parameter logic [7:0]          LFSR_SEED   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_LEN-1:0]   araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [1:0]            rresp,
    output logic [31:0]           rdata,
    input  logic                  bd_wen,
    input  logic [DEPTH_LOG2-1:0] bd_addr,
    input  logic [31:0]           bd_wdata,
    input  logic [3:0]            bd_wstrb
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [31:0] mem [WORDS];

    state_e               state_q, state_d;
    logic                 init_done_q, init_done_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;

    logic [7:0]           lfsr;
    logic                 unused_lfsr_bits;
    logic [3:0]           delay;
    logic [ADDR_LEN-1:0]  lk_addr, lk_off;
    logic [31:0]          lk_data;
    logic [1:0]           lk_resp;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (1'b1),
        .lfsr (lfsr)
    );

    assign unused_lfsr_bits = ^lfsr[7:3];
    assign delay = (DELAY_MODE != 0) ? {1'b0, lfsr[2:0]} : 4'(FIXED_DELAY);
    assign init_done_d = 1'b1;

    // Backdoor preload; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (bd_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (bd_wstrb[b]) begin
                    mem[bd_addr][8*b +: 8] <= bd_wdata[8*b +: 8];
                end
            end
        end
    end

    // The response is captured on the edge the FSM enters RESP. With a zero
    // delay that happens straight from IDLE, so the live araddr is decoded.
    always_comb begin
        lk_addr = (state_q == IDLE) ? araddr : addr_q;
        lk_off  = lk_addr - BASE_ADDR;
        lk_data = '0;
        lk_resp = RESP_OKAY;
        if (lk_off[1:0] != 2'b00) begin
            lk_resp = RESP_SLVERR;
        end else if ((lk_off >> (DEPTH_LOG2 + 2)) != '0) begin
            lk_resp = RESP_DECERR;
        end else begin
            lk_data = mem[lk_off[DEPTH_LOG2+1:2]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            init_done_q <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arvalid && arready) state_d = (delay == 4'd0) ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter holds the WAIT cycles still to go minus one, so a delay of
    // D spends exactly D cycles in WAIT before RESP.
    always_comb begin
        arready = (state_q == IDLE) && init_done_q;
        rvalid  = (state_q == RESP);
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (state_q == IDLE && arvalid && arready) begin
            addr_d = araddr;
            cnt_d  = delay - 4'd1;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (state_d == RESP && state_q != RESP) begin
            rdata_d = lk_data;
            rresp_d = lk_resp;
        end
    end

    assign rdata = rdata_q;
    assign rresp = rresp_q;

endmodule

// File: tb/tb_axil_isram.sv
// tb/tb_axil_isram.sv - self-checking bench for axil_isram (fixed 2, random, fixed 5 instances)
module tb_axil_isram;

    logic        clk = 1'b0;
    logic        rst_n    [3];
    logic        arvalid  [3];
    logic        arready  [3];
    logic [31:0] araddr   [3];
    logic        rvalid   [3];
    logic        rready   [3];
    logic [1:0]  rresp    [3];
    logic [31:0] rdata    [3];
    logic        bd_wen   [3];
    logic [13:0] bd_addr  [3];
    logic [31:0] bd_wdata [3];
    logic [3:0]  bd_wstrb [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel [3];

    logic [31:0] mdl [3][16384];

    logic        pend  [3];
    int          hs    [3];
    logic [31:0] exp_d [3];
    logic [1:0]  exp_r [3];
    logic        prv_v [3];
    logic        prv_r [3];
    logic [31:0] prv_d [3];
    logic [1:0]  prv_s [3];
    int          lat_min = 100;
    int          lat_max = 0;

    always #5 clk = ~clk;

    axil_isram #(.DELAY_MODE(0), .FIXED_DELAY(2)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr[0]),
        .rvalid(rvalid[0]), .rready(rready[0]), .rresp(rresp[0]), .rdata(rdata[0]),
        .bd_wen(bd_wen[0]), .bd_addr(bd_addr[0]), .bd_wdata(bd_wdata[0]), .bd_wstrb(bd_wstrb[0]));

    axil_isram #(.DELAY_MODE(1), .LFSR_SEED(8'hA5)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr[1]),
        .rvalid(rvalid[1]), .rready(rready[1]), .rresp(rresp[1]), .rdata(rdata[1]),
        .bd_wen(bd_wen[1]), .bd_addr(bd_addr[1]), .bd_wdata(bd_wdata[1]), .bd_wstrb(bd_wstrb[1]));

    axil_isram #(.DELAY_MODE(0), .FIXED_DELAY(5)) dut2 (
        .clk(clk), .rst_n(rst_n[2]), .arvalid(arvalid[2]), .arready(arready[2]), .araddr(araddr[2]),
        .rvalid(rvalid[2]), .rready(rready[2]), .rresp(rresp[2]), .rdata(rdata[2]),
        .bd_wen(bd_wen[2]), .bd_addr(bd_addr[2]), .bd_wdata(bd_wdata[2]), .bd_wstrb(bd_wstrb[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    // Expected response straight from the address map rules.
    function automatic logic [33:0] model(input int i, input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h8000_0000;
        if (off % 4 != 0) return {2'b10, 32'h0};
        if (off >= 32'd65536) return {2'b11, 32'h0};
        return {2'b00, mdl[i][off / 4]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) rel[i] <= rst_n[i] ? rel[i] + 1 : 0;
    end

    // Compare process: every cycle, every instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                check("rst_arready", arready[i], 0);
                check("rst_rvalid", rvalid[i], 0);
                check("rst_rdata", rdata[i], 0);
                check("rst_rresp", rresp[i], 0);
                pend[i]  = 1'b0;
                prv_v[i] = 1'b0;
                prv_r[i] = 1'b0;
            end else begin
                check($sformatf("arready%0d", i), arready[i], (rel[i] >= 1) && !pend[i]);
                if (rvalid[i]) begin
                    if (!pend[i]) begin
                        check($sformatf("rvalid_unexpected%0d", i), rvalid[i], 0);
                    end else if (!prv_v[i]) begin
                        int lat;
                        lat = cyc - hs[i];
                        if (i == 1) begin
                            check("lat_range1", (lat >= 1) && (lat <= 8), 1);
                            if (lat < lat_min) lat_min = lat;
                            if (lat > lat_max) lat_max = lat;
                        end else begin
                            check($sformatf("lat%0d", i), lat, (i == 0) ? 3 : 6);
                        end
                        check($sformatf("rdata%0d", i), rdata[i], exp_d[i]);
                        check($sformatf("rresp%0d", i), rresp[i], exp_r[i]);
                    end else if (!prv_r[i]) begin
                        check($sformatf("stable_rdata%0d", i), rdata[i], prv_d[i]);
                        check($sformatf("stable_rresp%0d", i), rresp[i], prv_s[i]);
                    end
                    if (rready[i]) pend[i] = 1'b0;
                end else if (prv_v[i] && !prv_r[i]) begin
                    check($sformatf("rvalid_dropped%0d", i), rvalid[i], 1);
                end
                if (arvalid[i] && arready[i]) begin
                    pend[i] = 1'b1;
                    hs[i]   = cyc;
                    {exp_r[i], exp_d[i]} = model(i, araddr[i]);
                end
                prv_v[i] = rvalid[i];
                prv_r[i] = rready[i];
                prv_d[i] = rdata[i];
                prv_s[i] = rresp[i];
            end
        end
    end

    task automatic bd_write(input int i, input int idx, input logic [31:0] d, input logic [3:0] s);
        bd_wen[i] = 1'b1; bd_addr[i] = 14'(idx); bd_wdata[i] = d; bd_wstrb[i] = s;
        @(posedge clk); #1;
        bd_wen[i] = 1'b0;
        for (int b = 0; b < 4; b++) if (s[b]) mdl[i][idx][8*b +: 8] = d[8*b +: 8];
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic do_read(input int i, input logic [31:0] addr, input int stall,
                           output logic [31:0] d, output logic [1:0] r, output int lat);
        int t;
        int h;
        d = '0; r = '0; lat = 0;
        araddr[i] = addr; arvalid[i] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready[i] && t < 40) begin @(negedge clk); t++; end
        if (!arready[i]) begin
            check("ar_timeout", 0, 1);
            arvalid[i] = 1'b0;
            return;
        end
        h = cyc;
        @(posedge clk); #1;
        arvalid[i] = 1'b0;
        if (stall == 0) rready[i] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rvalid[i] && t < 40) begin @(negedge clk); t++; end
        if (!rvalid[i]) begin
            check("r_timeout", 0, 1);
            rready[i] = 1'b0;
            return;
        end
        lat = cyc - h;
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1 rready[i] = 1'b1;
            @(negedge clk);
        end
        d = rdata[i]; r = rresp[i];
        @(posedge clk); #1;
        rready[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        logic [31:0] a;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; arvalid[i] = 1'b0; araddr[i] = '0; rready[i] = 1'b0;
            bd_wen[i] = 1'b0; bd_addr[i] = '0; bd_wdata[i] = '0; bd_wstrb[i] = '0;
            pend[i] = 1'b0; prv_v[i] = 1'b0; prv_r[i] = 1'b0; hs[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        check("arready_first_cycle", arready[0], 0);
        @(negedge clk);
        check("arready_second_cycle", arready[0], 1);
        @(posedge clk); #1;

        // Fixed delay 2
        bd_write(0, 0, 32'h0000_0013, 4'hF);
        do_read(0, 32'h8000_0000, 0, d, r, lat);
        check("basic_rdata", d, 32'h0000_0013);
        check("basic_rresp", r, 2'b00);
        check("basic_latency", lat, 3);
        check("arready_after_r", arready[0], 1);

        bd_write(0, 7, 32'hDEAD_BEEF, 4'hF);
        do_read(0, 32'h8000_001C, 5, d, r, lat);
        check("bp_rdata", d, 32'hDEAD_BEEF);
        check("bp_rresp", r, 2'b00);

        bd_write(0, 5, 32'h1122_3344, 4'hF);
        bd_write(0, 5, 32'hAABB_CCDD, 4'b0101);
        do_read(0, 32'h8000_0014, 0, d, r, lat);
        check("strobe_rdata", d, 32'h11BB_33DD);

        bd_write(0, 16383, 32'hCAFE_F00D, 4'hF);
        do_read(0, 32'h8000_FFFC, 1, d, r, lat);
        check("last_word_rdata", d, 32'hCAFE_F00D);
        check("last_word_rresp", r, 2'b00);

        do_read(0, 32'h8000_0002, 0, d, r, lat);
        check("slverr_rresp", r, 2'b10);
        check("slverr_rdata", d, 32'h0);
        do_read(0, 32'h8001_0000, 0, d, r, lat);
        check("decerr_top_rresp", r, 2'b11);
        check("decerr_top_rdata", d, 32'h0);
        do_read(0, 32'h7FFF_FFFC, 0, d, r, lat);
        check("decerr_under_rresp", r, 2'b11);

        // Random delay
        for (int k = 0; k < 256; k++) bd_write(1, k, $urandom, 4'hF);
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 15) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'h8000_0002 : 32'h9000_0000;
            else
                a = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 4;
            do_read(1, a, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0, d, r, lat);
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        check("random_min_latency", lat_min, 1);
        check("random_max_latency", lat_max, 8);

        // Reset in the middle of WAIT
        bd_write(2, 3, 32'h55AA_1234, 4'hF);
        araddr[2] = 32'h8000_000C; arvalid[2] = 1'b1;
        @(negedge clk);
        check("mid_wait_arready", arready[2], 1);
        @(posedge clk); #1;
        arvalid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n[2] = 1'b0;
        @(negedge clk);
        check("mid_wait_rvalid_low", rvalid[2], 0);
        repeat (2) @(posedge clk);
        #1 rst_n[2] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        do_read(2, 32'h8000_000C, 1, d, r, lat);
        check("after_reset_rdata", d, 32'h55AA_1234);
        check("after_reset_latency", lat, 6);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
